// File: rtl/crossbar_switch_rr.sv
// Registered NxN crossbar: per-input valid/ready, per-output round-robin
// arbitration into a one-entry output slot, optional barrel-only mapping check.
module crossbar_switch_rr #(
    parameter int unsigned N           = 8,
    parameter int unsigned W           = 8,
    parameter int unsigned BARREL_ONLY = 0
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [N-1:0]             in_valid,
    input  logic [N*W-1:0]           in_data,
    input  logic [N*$clog2(N)-1:0]   in_dest,
    output logic [N-1:0]             in_ready,
    input  logic [$clog2(N)-1:0]     shift,
    input  logic [N-1:0]             output_enable,
    output logic [N-1:0]             out_valid,
    output logic [N*W-1:0]           out_data,
    input  logic [N-1:0]             out_ready,
    output logic                     mapping_error,
    output logic                     collision_error
);

    localparam int unsigned LW = $clog2(N);

    logic [N-1:0]  slot_v_q, slot_v_d;
    logic [W-1:0]  slot_data_q [N];
    logic [W-1:0]  slot_data_d [N];
    logic [LW-1:0] rr_q [N];
    logic [LW-1:0] rr_d [N];
    logic          mapping_error_q, mapping_error_d;
    logic          collision_error_q, collision_error_d;

    logic [LW-1:0] dest [N];
    logic [N-1:0]  legal, illegal, granted, can_load, load, pop;
    logic          found, req, in_window;
    int unsigned   nreq;

    always_comb begin
        for (int unsigned i = 0; i < N; i++) begin
            dest[i]    = in_dest[i*LW +: LW];
            legal[i]   = (BARREL_ONLY == 0) || (dest[i] == LW'(i) + shift);
            illegal[i] = in_valid[i] && !legal[i];
        end
    end

    // Round-robin search in two passes: indices >= rr first, then the wrap-around.
    always_comb begin
        granted           = '0;
        can_load          = '0;
        load              = '0;
        pop               = '0;
        slot_v_d          = slot_v_q;
        collision_error_d = 1'b0;
        found             = 1'b0;
        req               = 1'b0;
        in_window         = 1'b0;
        nreq              = 0;
        for (int unsigned d = 0; d < N; d++) begin
            slot_data_d[d] = slot_data_q[d];
            rr_d[d]        = rr_q[d];
        end
        for (int unsigned d = 0; d < N; d++) begin
            can_load[d] = output_enable[d] && (!slot_v_q[d] || out_ready[d]);
            pop[d]      = slot_v_q[d] && output_enable[d] && out_ready[d];
            nreq        = 0;
            found       = 1'b0;
            for (int unsigned p = 0; p < 2; p++) begin
                for (int unsigned i = 0; i < N; i++) begin
                    req       = in_valid[i] && legal[i] && (dest[i] == LW'(d));
                    in_window = (p == 0) ? (i >= 32'(rr_q[d])) : (i < 32'(rr_q[d]));
                    if (p == 0 && req) begin
                        nreq = nreq + 1;
                    end
                    if (req && in_window && !found && can_load[d]) begin
                        found          = 1'b1;
                        granted[i]     = 1'b1;
                        load[d]        = 1'b1;
                        slot_data_d[d] = in_data[i*W +: W];
                        rr_d[d]        = LW'(i + 1);
                    end
                end
            end
            if (nreq >= 2) begin
                collision_error_d = 1'b1;
            end
            if (load[d]) begin
                slot_v_d[d] = 1'b1;
            end else if (pop[d]) begin
                slot_v_d[d] = 1'b0;
            end
        end
        mapping_error_d = |illegal;
    end

    always_comb begin
        in_ready  = (granted | illegal) & {N{rst_n}};
        out_valid = slot_v_q & output_enable;
        out_data  = '0;
        for (int unsigned d = 0; d < N; d++) begin
            if (out_valid[d]) begin
                out_data[d*W +: W] = slot_data_q[d];
            end
        end
        mapping_error   = mapping_error_q;
        collision_error = collision_error_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            slot_v_q          <= '0;
            mapping_error_q   <= 1'b0;
            collision_error_q <= 1'b0;
            for (int unsigned d = 0; d < N; d++) begin
                slot_data_q[d] <= '0;
                rr_q[d]        <= '0;
            end
        end else begin
            slot_v_q          <= slot_v_d;
            mapping_error_q   <= mapping_error_d;
            collision_error_q <= collision_error_d;
            for (int unsigned d = 0; d < N; d++) begin
                slot_data_q[d] <= slot_data_d[d];
                rr_q[d]        <= rr_d[d];
            end
        end
    end

endmodule

// File: tb/tb_crossbar_switch_rr.sv
// Scoreboard bench for crossbar_switch_rr: accepted words queued per output,
// checked as each output hands a word to its sink.
module tb_crossbar_switch_rr;

    localparam int N  = 8;
    localparam int W  = 8;
    localparam int LW = 3;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic             rst_n;
    logic [N-1:0]     in_valid, output_enable, out_ready;
    logic [N*W-1:0]   in_data;
    logic [N*LW-1:0]  in_dest;
    logic [LW-1:0]    shift;
    logic [N-1:0]     in_ready, out_valid, b_in_ready, b_out_valid;
    logic [N*W-1:0]   out_data, b_out_data;
    logic             merr, cerr, b_merr, b_cerr;

    int total = 0;
    int bad   = 0;
    bit mon_en = 1'b0;
    logic [W-1:0] sbq [N][$];

    crossbar_switch_rr #(.N(N), .W(W), .BARREL_ONLY(0)) u_dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_data(in_data),
        .in_dest(in_dest), .in_ready(in_ready), .shift(shift),
        .output_enable(output_enable), .out_valid(out_valid), .out_data(out_data),
        .out_ready(out_ready), .mapping_error(merr), .collision_error(cerr)
    );

    crossbar_switch_rr #(.N(N), .W(W), .BARREL_ONLY(1)) u_dut_b (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_data(in_data),
        .in_dest(in_dest), .in_ready(b_in_ready), .shift(shift),
        .output_enable(output_enable), .out_valid(b_out_valid), .out_data(b_out_data),
        .out_ready(out_ready), .mapping_error(b_merr), .collision_error(b_cerr)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drv(input int i, input int dst, input logic [7:0] data);
        in_valid[i]          = 1'b1;
        in_dest[i*LW +: LW]  = LW'(dst);
        in_data[i*W +: W]    = data;
    endtask

    task automatic idle();
        in_valid = '0;
    endtask

    task automatic sb_clear();
        for (int d = 0; d < N; d++) sbq[d].delete();
    endtask

    task automatic do_reset();
        for (int d = 0; d < N; d++) check("sb_drain", 64'(sbq[d].size()), 0);
        rst_n = 1'b0;
        idle();
        out_ready     = '1;
        output_enable = '1;
        shift         = '0;
        sb_clear();
        tick();
        tick();
        rst_n = 1'b1;
    endtask

    // Pop side of the scoreboard: a word leaves output d when valid && ready.
    always @(negedge clk) begin
        if (mon_en) begin
            for (int d = 0; d < N; d++) begin
                if (sbq[d].size() == 0) begin
                    check("sb_extra", 64'(out_valid[d] && out_ready[d]), 0);
                end else if (out_valid[d] && out_ready[d]) begin
                    check("sb_data", 64'(out_data[d*W +: W]), 64'(sbq[d].pop_front()));
                end
                if (!out_valid[d]) check("out_zero", 64'(out_data[d*W +: W]), 0);
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        int order [3];
        int g;
        logic [7:0] seq;
        order = '{1, 3, 6};

        rst_n = 1'b0; in_valid = '1; in_data = '0; in_dest = '0; shift = '0;
        output_enable = '1; out_ready = '1;
        #3;
        check("rst_in_ready", in_ready, 0);
        check("rst_out_valid", out_valid, 0);
        check("rst_out_data", out_data, 0);
        check("rst_errs", {merr, cerr}, 0);
        idle();
        tick();
        rst_n = 1'b1;
        mon_en = 1'b1;

        // permutation: in_dest[i] = 7-i
        for (int i = 0; i < N; i++) drv(i, 7 - i, 8'(16 + i));
        @(negedge clk);
        check("perm_ready", in_ready, 8'hFF);
        for (int i = 0; i < N; i++) sbq[7 - i].push_back(8'(16 + i));
        tick();
        idle();
        @(negedge clk);
        check("perm_out_valid", out_valid, 8'hFF);
        check("perm_coll", cerr, 0);
        check("perm_merr", merr, 0);
        tick();

        // contention: inputs 1, 3, 6 -> output 2
        do_reset();
        seq = 8'hA0;
        for (int k = 0; k < 3; k++) begin
            drv(order[k], 2, seq);
            seq++;
        end
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            g = order[k % 3];
            check("cont_ready", in_ready, 64'(1) << g);
            if (k > 0) check("cont_coll", cerr, 1);
            sbq[2].push_back(in_data[g*W +: W]);
            tick();
            in_data[g*W +: W] = seq;
            seq++;
        end
        in_valid[3] = 1'b0;
        in_valid[6] = 1'b0;
        @(negedge clk);
        check("cont_wrap_ready", in_ready, 8'h02);
        check("cont_coll_last", cerr, 1);
        sbq[2].push_back(in_data[1*W +: W]);
        tick();
        idle();
        @(negedge clk);
        check("cont_coll_clear", cerr, 0);
        tick();

        // backpressure on output 0
        do_reset();
        out_ready[0] = 1'b0;
        drv(0, 0, 8'h55);
        @(negedge clk);
        check("bp_fill_ready", in_ready, 8'h01);
        sbq[0].push_back(8'h55);
        tick();
        idle();
        drv(4, 0, 8'h77);
        for (int k = 0; k < 2; k++) begin
            @(negedge clk);
            check("bp_stall", in_ready, 0);
            check("bp_hold", out_data[W-1:0], 8'h55);
            tick();
        end
        out_ready[0] = 1'b1;
        @(negedge clk);
        check("bp_accept", in_ready, 8'h10);
        sbq[0].push_back(8'h77);
        tick();
        idle();
        @(negedge clk);
        tick();

        // output enable on output 6
        do_reset();
        drv(1, 6, 8'h66);
        @(negedge clk);
        check("en_fill_ready", in_ready, 8'h02);
        sbq[6].push_back(8'h66);
        tick();
        idle();
        output_enable[6] = 1'b0;
        drv(2, 6, 8'h99);
        for (int k = 0; k < 2; k++) begin
            @(negedge clk);
            check("en_stall", in_ready, 0);
            check("en_valid", out_valid[6], 0);
            tick();
        end
        output_enable[6] = 1'b1;
        @(negedge clk);
        check("en_resume_ready", in_ready, 8'h04);
        sbq[6].push_back(8'h99);
        tick();
        idle();
        @(negedge clk);
        tick();

        // barrel mode, shift = 3
        do_reset();
        mon_en = 1'b0;
        shift = 3'd3;
        drv(2, 5, 8'h25);
        @(negedge clk);
        check("bar_ready_ok", b_in_ready, 8'h04);
        tick();
        idle();
        @(negedge clk);
        check("bar_deliver", b_out_data[5*W +: W], 8'h25);
        check("bar_valid", b_out_valid, 8'h20);
        check("bar_merr_quiet", b_merr, 0);
        tick();
        drv(2, 4, 8'h24);
        @(negedge clk);
        check("bar_ready_bad", b_in_ready, 8'h04);
        tick();
        idle();
        @(negedge clk);
        check("bar_merr", b_merr, 1);
        check("bar_no_deliver", b_out_valid, 0);
        tick();
        @(negedge clk);
        check("bar_merr_clear", b_merr, 0);
        tick();

        // asynchronous reset mid-stream, then round-robin restarts at 0
        do_reset();
        mon_en = 1'b1;
        drv(0, 3, 8'h30);
        drv(1, 3, 8'h31);
        drv(5, 2, 8'h52);
        @(negedge clk);
        check("pre_rst_ready", in_ready, 8'h21);
        sbq[3].push_back(8'h30);
        sbq[2].push_back(8'h52);
        tick();
        check("pre_rst_coll", cerr, 1);
        #1;
        rst_n = 1'b0;
        sb_clear();
        #1;
        check("arst_out_valid", out_valid, 0);
        check("arst_out_data", out_data, 0);
        check("arst_errs", {merr, cerr}, 0);
        check("arst_in_ready", in_ready, 0);
        idle();
        tick();
        tick();
        rst_n = 1'b1;
        drv(0, 3, 8'h40);
        drv(5, 3, 8'h45);
        @(negedge clk);
        check("rr_restart", in_ready, 8'h01);
        sbq[3].push_back(8'h40);
        tick();
        idle();
        @(negedge clk);
        tick();
        for (int d = 0; d < N; d++) check("sb_drain", 64'(sbq[d].size()), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
